// File: rtl/serial_magnitude_comparator.sv
// Serial unsigned magnitude comparator. Two operand bits are compared per clock,
// starting with the most significant pair. The run ends early once a pair differs.
// EQ/LT/GT are registered and hold their values until the next completion.
// WIDTH must be even and at least 2.
module serial_magnitude_comparator #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             EQ,
  output logic             LT,
  output logic             GT
);

  localparam int unsigned Pairs = WIDTH / 2;
  localparam int unsigned CntW  = $clog2(Pairs + 1);

  typedef enum logic {StIdle, StRun} fsmState;

  fsmState          state, stateNext;
  logic [WIDTH-1:0] aShift, aShiftNext;
  logic [WIDTH-1:0] bShift, bShiftNext;
  logic             eqR, eqRNext;
  logic             ltR, ltRNext;
  logic [CntW-1:0]  cnt, cntNext;
  logic             doneNext;
  logic             eqNext, ltNext, gtNext;

  logic [1:0] pairA, pairB;
  logic       msbEq;
  logic       sEq, sLt;
  logic       finish;

  // 2-bit compare slice on the current MSB pair, chained through the cascade registers.
  always_comb begin
    pairA  = aShift[WIDTH-1 -: 2];
    pairB  = bShift[WIDTH-1 -: 2];
    msbEq  = pairA[1] ~^ pairB[1];
    sEq    = eqR & msbEq & (pairA[0] ~^ pairB[0]);
    sLt    = ltR | (eqR & ~pairA[1] & pairB[1]) | (eqR & msbEq & ~pairA[0] & pairB[0]);
    // Once a pair differs the verdict is fixed, so the remaining pairs are skipped.
    finish = (cnt == CntW'(1)) | ~sEq;
  end

  // Next-state logic for the FSM, the datapath and the result registers.
  always_comb begin
    stateNext  = state;
    aShiftNext = aShift;
    bShiftNext = bShift;
    eqRNext    = eqR;
    ltRNext    = ltR;
    cntNext    = cnt;
    doneNext   = 1'b0;
    eqNext     = EQ;
    ltNext     = LT;
    gtNext     = GT;
    unique case (state)
      StIdle: begin
        if (start) begin
          aShiftNext = A;
          bShiftNext = B;
          eqRNext    = 1'b1;
          ltRNext    = 1'b0;
          cntNext    = CntW'(Pairs);
          stateNext  = StRun;
        end
      end
      StRun: begin
        eqRNext    = sEq;
        ltRNext    = sLt;
        aShiftNext = aShift << 2;
        bShiftNext = bShift << 2;
        cntNext    = cnt - CntW'(1);
        if (finish) begin
          eqNext    = sEq;
          ltNext    = sLt;
          gtNext    = ~sEq & ~sLt;
          doneNext  = 1'b1;
          stateNext = StIdle;
        end
      end
      default: stateNext = StIdle;
    endcase
  end

  // State and result registers; reset discards any comparison in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= StIdle;
      aShift <= '0;
      bShift <= '0;
      eqR    <= 1'b1;
      ltR    <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
      EQ     <= 1'b0;
      LT     <= 1'b0;
      GT     <= 1'b0;
    end else begin
      state  <= stateNext;
      aShift <= aShiftNext;
      bShift <= bShiftNext;
      eqR    <= eqRNext;
      ltR    <= ltRNext;
      cnt    <= cntNext;
      done   <= doneNext;
      EQ     <= eqNext;
      LT     <= ltNext;
      GT     <= gtNext;
    end
  end

  assign busy = (state == StRun);

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator (WIDTH=8). Inputs change and
// outputs are sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_serial_magnitude_comparator;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] A, B;
  logic       busy, done, EQ, LT, GT;

  int unsigned total  = 0;
  int unsigned passed = 0;
  logic [2:0]  prevRes;   // {EQ, LT, GT} expected to be held

  serial_magnitude_comparator #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .EQ    (EQ),
    .LT    (LT),
    .GT    (GT)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Compares {busy, done, EQ, LT, GT} against an expected vector.
  task automatic check(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {busy, done, EQ, LT, GT};
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: {busy,done,EQ,LT,GT} got %b expected %b", tag, obs, exp);
  endtask

  // Issues one comparison at the current falling edge and follows it to its done cycle.
  // runCycles is the number of busy cycles; res is the expected {EQ,LT,GT}.
  task automatic runCmp(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input int runCycles, input logic [2:0] res);
    A = a;
    B = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " accept"}, {2'b10, prevRes});
    for (int i = 1; i < runCycles; i++) begin
      @(negedge clk);
      check({tag, " run"}, {2'b10, prevRes});
    end
    @(negedge clk);
    check({tag, " done"}, {2'b01, res});
    prevRes = res;
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    A       = '0;
    B       = '0;
    prevRes = 3'b000;
    @(negedge clk);
    check("reset", 5'b00000);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle after reset", 5'b00000);

    // Equal operands: full four-pair run.
    runCmp("eq A5", 8'hA5, 8'hA5, 4, 3'b100);
    @(negedge clk);
    check("eq hold", 5'b00100);

    // Difference only in the LSB pair.
    runCmp("lt 3C/3D", 8'h3C, 8'h3D, 4, 3'b010);
    @(negedge clk);
    check("lt hold", 5'b00010);

    // MSB pair decides immediately.
    runCmp("gt 80/7F", 8'h80, 8'h7F, 1, 3'b001);
    @(negedge clk);
    check("gt hold", 5'b00001);

    // start during RUN is ignored; operand changes during RUN have no effect.
    A = 8'h10;
    B = 8'h20;
    start = 1'b1;
    @(negedge clk);
    A = 8'hFF;
    B = 8'hFF;
    check("busy accept", {2'b10, prevRes});
    @(negedge clk);
    start = 1'b0;
    check("busy ignore", {2'b10, prevRes});
    @(negedge clk);
    check("busy done", 5'b01010);
    prevRes = 3'b010;

    // Back-to-back: start asserted during the done cycle.
    runCmp("b2b 01/00", 8'h01, 8'h00, 4, 3'b001);
    @(negedge clk);
    check("b2b hold", 5'b00001);

    // Reset in the middle of a run: outputs clear at once and no done follows.
    A = 8'hA5;
    B = 8'hA5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre-reset run", 5'b10001);
    #10;
    rst_n = 1'b0;
    #1;
    check("async reset", 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no done after reset", 5'b00000);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
